manticore_processor: RTL and testbench

Single-core bootloadable processor tile. A host streams a program and run parameters in as 16-bit packets. The core then executes the program body once per virtual cycle for a fixed number of virtual cycles and reports pass/fail through a 16-bit exception id. It is the execution element a host or testbench wraps; the cache and global-memory periphery are stubbed in this revision.

---
 rtl/manticore_pkg.sv | 40 ++++
 rtl/mp_regfile.sv | 25 ++
 rtl/manticore_processor.sv | 203 ++++++++++++++++++++
 tb/tb_manticore_processor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/manticore_pkg.sv
// Shared types and constants for the manticore processor tile: opcodes,
// boot/exec states, instruction field positions and packet addresses.
package manticore_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_SET    = 4'd1,
    OP_ADD    = 4'd2,
    OP_SUB    = 4'd3,
    OP_AND    = 4'd4,
    OP_XOR    = 4'd5,
    OP_EXPECT = 4'd6,
    OP_SEND   = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BODY  = 3'd1,
    S_EPI   = 3'd2,
    S_SLEEP = 3'd3,
    S_COUNT = 3'd4,
    S_EXEC  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 3;
  localparam int RD_LSB  = 4;
  localparam int RD_MSB  = 14;
  localparam int RS1_LSB = 16;
  localparam int RS1_MSB = 26;
  localparam int RS2_LSB = 32;
  localparam int RS2_MSB = 42;
  localparam int IMM_LSB = 48;
  localparam int IMM_MSB = 63;

  localparam logic [10:0] ADDR_CTRL = 11'd0;
  localparam logic [10:0] ADDR_BODY = 11'd1;

endpackage

// File: rtl/mp_regfile.sv
// 16-bit register file: two combinational read ports, one write port that
// lands at the clock edge. Contents are deliberately not reset.
module mp_regfile #(
  parameter int DEPTH = 2048
) (
  input  logic        clock,
  input  logic [10:0] raddr1,
  input  logic [10:0] raddr2,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2,
  input  logic        wen,
  input  logic [10:0] waddr,
  input  logic [15:0] wdata
);

  logic [15:0] mem [DEPTH];

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/manticore_processor.sv
// Bootloadable single-core tile: packet-driven boot FSM, one-instruction-per-
// clock body execution, virtual-cycle countdown and sticky exception report.
module manticore_processor
  import manticore_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int RF_DEPTH   = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] io_packet_in_data,
  input  logic [10:0] io_packet_in_address,
  input  logic        io_packet_in_valid,
  output logic [15:0] io_packet_out_data,
  output logic [10:0] io_packet_out_address,
  output logic        io_packet_out_valid,
  output logic [3:0]  io_packet_out_xHops,
  output logic [3:0]  io_packet_out_yHops,
  output logic        io_periphery_active,
  output logic [47:0] io_periphery_cache_addr,
  output logic [15:0] io_periphery_cache_wdata,
  output logic        io_periphery_cache_start,
  output logic [1:0]  io_periphery_cache_cmd,
  input  logic [15:0] io_periphery_cache_rdata,
  input  logic        io_periphery_cache_done,
  input  logic        io_periphery_cache_idle,
  output logic        io_periphery_gmem_access_failure_error,
  output logic        io_periphery_exception_error,
  output logic [15:0] io_periphery_exception_id,
  output logic        io_periphery_debug_time,
  output logic        io_periphery_dynamic_cycle,
  output logic [2:0]  debug_state
);

  localparam int          IW       = $clog2(IMEM_DEPTH);
  localparam logic [15:0] IMEM_LIM = 16'(IMEM_DEPTH);

  state_e      state, state_n;
  logic [15:0] body_len, epi, sleep, count, instr_cnt;
  logic [1:0]  word_cnt;
  logic [47:0] asm_q;
  logic [17:0] vcnt, total;
  logic [15:0] eff_len;
  logic [63:0] imem [IMEM_DEPTH];
  logic [63:0] instr;
  opcode_e     op;
  logic [15:0] rd1, rd2, wr_data, raise_id;
  logic        pkt_ctrl, pkt_body, word_last, body_phase, end_vc;
  logic        wr_en, send, raise;
  logic        exc_err;
  logic [15:0] exc_id;

  assign pkt_ctrl  = io_packet_in_valid && (io_packet_in_address == ADDR_CTRL);
  assign pkt_body  = io_packet_in_valid && (io_packet_in_address == ADDR_BODY);
  assign word_last = pkt_body && (word_cnt == 2'd3);

  // Instructions beyond the imem capacity are dropped, so the body is clipped.
  assign eff_len    = (body_len > IMEM_LIM) ? IMEM_LIM : body_len;
  assign total      = {2'b0, eff_len} + {2'b0, epi} + {2'b0, sleep};
  assign body_phase = (state == S_EXEC) && (vcnt < {2'b0, eff_len});
  assign end_vc     = (vcnt + 18'd1) >= total;

  assign instr = imem[vcnt[IW-1:0]];
  assign op    = opcode_e'(instr[OP_MSB:OP_LSB]);

  mp_regfile #(.DEPTH(RF_DEPTH)) u_regfile (
    .clock  (clock),
    .raddr1 (instr[RS1_MSB:RS1_LSB]),
    .raddr2 (instr[RS2_MSB:RS2_LSB]),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .wen    (wr_en),
    .waddr  (instr[RD_MSB:RD_LSB]),
    .wdata  (wr_data)
  );

  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    wr_data  = 16'd0;
    send     = 1'b0;
    raise    = 1'b0;
    raise_id = 16'd0;
    case (state)
      S_IDLE:  if (pkt_ctrl) state_n = (io_packet_in_data == 16'd0) ? S_EPI : S_BODY;
      S_BODY:  if (word_last && (instr_cnt == body_len - 16'd1)) state_n = S_EPI;
      S_EPI:   if (pkt_ctrl) state_n = S_SLEEP;
      S_SLEEP: if (pkt_ctrl) state_n = S_COUNT;
      S_COUNT: begin
        if (pkt_ctrl) begin
          if (io_packet_in_data == 16'd0) begin
            raise   = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (body_phase) begin
          case (op)
            OP_SET:    begin wr_en = 1'b1; wr_data = instr[IMM_MSB:IMM_LSB]; end
            OP_ADD:    begin wr_en = 1'b1; wr_data = rd1 + rd2; end
            OP_SUB:    begin wr_en = 1'b1; wr_data = rd1 - rd2; end
            OP_AND:    begin wr_en = 1'b1; wr_data = rd1 & rd2; end
            OP_XOR:    begin wr_en = 1'b1; wr_data = rd1 ^ rd2; end
            OP_EXPECT: begin
              if (rd1 != rd2) begin
                raise    = 1'b1;
                raise_id = instr[IMM_MSB:IMM_LSB];
              end
            end
            OP_SEND:   send = 1'b1;
            default:   ;
          endcase
        end
        // A failing EXPECT on the last body slot wins over countdown expiry.
        if (!raise && end_vc && (count == 16'd1)) raise = 1'b1;
        if (raise) state_n = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= S_IDLE;
      body_len              <= '0;
      epi                   <= '0;
      sleep                 <= '0;
      count                 <= '0;
      instr_cnt             <= '0;
      word_cnt              <= '0;
      asm_q                 <= '0;
      vcnt                  <= '0;
      exc_err               <= 1'b0;
      exc_id                <= '0;
      io_packet_out_valid   <= 1'b0;
      io_packet_out_data    <= '0;
      io_packet_out_address <= '0;
      io_packet_out_xHops   <= '0;
      io_packet_out_yHops   <= '0;
    end else begin
      state               <= state_n;
      io_packet_out_valid <= send;
      if (send) begin
        io_packet_out_data    <= rd1;
        io_packet_out_address <= instr[RD_MSB:RD_LSB];
        io_packet_out_xHops   <= instr[IMM_LSB+3:IMM_LSB];
        io_packet_out_yHops   <= instr[IMM_LSB+7:IMM_LSB+4];
      end
      if (raise) begin
        exc_err <= 1'b1;
        exc_id  <= raise_id;
      end
      case (state)
        S_IDLE: if (pkt_ctrl) begin
          body_len  <= io_packet_in_data;
          instr_cnt <= '0;
          word_cnt  <= '0;
        end
        S_BODY: if (pkt_body) begin
          word_cnt <= word_cnt + 2'd1;
          if (word_last) instr_cnt <= instr_cnt + 16'd1;
          else asm_q[{word_cnt, 4'b0000} +: 16] <= io_packet_in_data;
        end
        S_EPI:   if (pkt_ctrl) epi <= io_packet_in_data;
        S_SLEEP: if (pkt_ctrl) sleep <= io_packet_in_data;
        S_COUNT: if (pkt_ctrl) begin
          count <= io_packet_in_data;
          vcnt  <= '0;
        end
        S_EXEC: begin
          vcnt <= end_vc ? 18'd0 : vcnt + 18'd1;
          if (end_vc) count <= count - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if ((state == S_BODY) && word_last && (instr_cnt < IMEM_LIM))
      imem[instr_cnt[IW-1:0]] <= {io_packet_in_data, asm_q};
  end

  assign io_periphery_active                    = (state == S_EXEC);
  assign io_periphery_debug_time                = body_phase;
  assign io_periphery_dynamic_cycle             = (state == S_EXEC) && (vcnt == 18'd0);
  assign io_periphery_exception_error           = exc_err;
  assign io_periphery_exception_id              = exc_id;
  assign io_periphery_cache_addr                = '0;
  assign io_periphery_cache_wdata               = '0;
  assign io_periphery_cache_start               = 1'b0;
  assign io_periphery_cache_cmd                 = '0;
  assign io_periphery_gmem_access_failure_error = 1'b0;
  assign debug_state                            = state;

  logic unused;
  assign unused = ^{io_periphery_cache_rdata, io_periphery_cache_done,
                    io_periphery_cache_idle, instr[15], instr[31:27], instr[47:43]};

endmodule

// File: tb/tb_manticore_processor.sv
// Directed bench for manticore_processor: driver boots programs, a negedge
// monitor scores SEND packets and exception rises against an expected queue.
module tb_manticore_processor;
  import manticore_pkg::*;

  localparam int W = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = '0;
  logic [10:0] in_addr = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out_data;
  logic [10:0] out_addr;
  logic        out_valid;
  logic [3:0]  out_x, out_y;
  logic        active;
  logic [47:0] cache_addr;
  logic [15:0] cache_wdata;
  logic        cache_start;
  logic [1:0]  cache_cmd;
  logic        gmem_err, exc_err, debug_time, dyn_cycle;
  logic [15:0] exc_id;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exec_base = 0;
  logic prev_err = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [63:0]  prog[$];

  manticore_processor dut (
    .clock                                  (clock),
    .reset                                  (reset),
    .io_packet_in_data                      (in_data),
    .io_packet_in_address                   (in_addr),
    .io_packet_in_valid                     (in_valid),
    .io_packet_out_data                     (out_data),
    .io_packet_out_address                  (out_addr),
    .io_packet_out_valid                    (out_valid),
    .io_packet_out_xHops                    (out_x),
    .io_packet_out_yHops                    (out_y),
    .io_periphery_active                    (active),
    .io_periphery_cache_addr                (cache_addr),
    .io_periphery_cache_wdata               (cache_wdata),
    .io_periphery_cache_start               (cache_start),
    .io_periphery_cache_cmd                 (cache_cmd),
    .io_periphery_cache_rdata               (16'h0000),
    .io_periphery_cache_done                (1'b0),
    .io_periphery_cache_idle                (1'b1),
    .io_periphery_gmem_access_failure_error (gmem_err),
    .io_periphery_exception_error           (exc_err),
    .io_periphery_exception_id              (exc_id),
    .io_periphery_debug_time                (debug_time),
    .io_periphery_dynamic_cycle             (dyn_cycle),
    .debug_state                            (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // ---------------- helpers ----------------
  function automatic logic [63:0] ins(input logic [3:0] op, input logic [10:0] rd,
                                      input logic [10:0] rs1, input logic [10:0] rs2,
                                      input logic [15:0] imm);
    return {imm, 5'b0, rs2, 5'b0, rs1, 1'b0, rd, op};
  endfunction

  // Event record: tag (1 = SEND, 2 = exception rise), payload, execution cycle.
  function automatic logic [W-1:0] ev(input logic [3:0] tag, input logic [38:0] payload,
                                      input logic [7:0] k);
    return {13'b0, tag, payload, k};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic score(input string name, input logic [W-1:0] act);
    logic [W-1:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event actual=%h required=none", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
    end
  endtask

  task automatic drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: missing events actual=0 required=%0d", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_outs"}, {out_valid, out_data, out_addr, out_x, out_y, active, exc_err,
                            exc_id, debug_time, dyn_cycle, gmem_err, cache_start}, '0);
    check({name, "_cache"}, {cache_addr, cache_wdata, cache_cmd}, '0);
    check({name, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pkt(input logic [10:0] a, input logic [15:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [63:0] i);
    for (int w = 0; w < 4; w++) pkt(ADDR_BODY, i[w*16 +: 16]);
  endtask

  task automatic boot(input logic [15:0] epi, input logic [15:0] sleep, input logic [15:0] count);
    pkt(ADDR_CTRL, 16'(prog.size()));
    // An off-address packet between body words must be ignored.
    pkt(11'd5, 16'hDEAD);
    foreach (prog[i]) send_instr(prog[i]);
    pkt(ADDR_CTRL, epi);
    pkt(ADDR_CTRL, sleep);
    exec_base = cyc + 1;
    pkt(ADDR_CTRL, count);
  endtask

  task automatic pass_program();
    prog = '{ins(4'd1, 11'd1, 11'd0, 11'd0, 16'd5),
             ins(4'd1, 11'd2, 11'd0, 11'd0, 16'd5),
             ins(4'd6, 11'd0, 11'd1, 11'd2, 16'h8001)};
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [7:0] k;
    k = 8'(cyc - exec_base + 1);
    if (out_valid) score("send_pkt", ev(4'h1, {4'b0, out_data, out_addr, out_x, out_y}, k));
    if (exc_err && !prev_err) score("exception", ev(4'h2, {23'b0, exc_id}, k));
    prev_err <= exc_err;
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clock);

    // Pass run: 5-clock virtual cycle, COUNT=2 -> id 0 after 10 clocks.
    pass_program();
    exp_q.push_back(ev(4'h2, 39'h0000, 8'd11));
    boot(16'd1, 16'd1, 16'd2);
    check("pass_active", {active, dyn_cycle, debug_time}, 3'b111);
    repeat (14) @(negedge clock);
    check("pass_final", {active, exc_err, exc_id}, {1'b0, 1'b1, 16'h0000});
    drained("pass_drain");

    // Fail run: EXPECT at clock 3 fails.
    do_reset();
    prog = '{ins(4'd1, 11'd1, 11'd0, 11'd0, 16'd1),
             ins(4'd1, 11'd2, 11'd0, 11'd0, 16'd2),
             ins(4'd6, 11'd0, 11'd1, 11'd2, 16'h8006)};
    exp_q.push_back(ev(4'h2, 39'h8006, 8'd4));
    boot(16'd1, 16'd1, 16'd5);
    repeat (12) @(negedge clock);
    check("fail_held", {active, exc_err, exc_id}, {1'b0, 1'b1, 16'h8006});
    check("fail_state", 64'(dbg_state), 64'(S_DONE));
    drained("fail_drain");

    // Wrap arithmetic: 0xFFFF + 2 == 1.
    do_reset();
    prog = '{ins(4'd1, 11'd1, 11'd0, 11'd0, 16'hFFFF),
             ins(4'd1, 11'd2, 11'd0, 11'd0, 16'd2),
             ins(4'd2, 11'd3, 11'd1, 11'd2, 16'd0),
             ins(4'd1, 11'd4, 11'd0, 11'd0, 16'd1),
             ins(4'd6, 11'd0, 11'd3, 11'd4, 16'h8002)};
    exp_q.push_back(ev(4'h2, 39'h0000, 8'd6));
    boot(16'd0, 16'd0, 16'd1);
    repeat (8) @(negedge clock);
    drained("wrap_drain");

    // SEND: packet seen the cycle after issue, same cycle as countdown expiry.
    do_reset();
    prog = '{ins(4'd1, 11'd5, 11'd0, 11'd0, 16'h1234),
             ins(4'd7, 11'd7, 11'd5, 11'd0, 16'h0021)};
    exp_q.push_back(ev(4'h1, {4'b0, 16'h1234, 11'd7, 4'd1, 4'd2}, 8'd3));
    exp_q.push_back(ev(4'h2, 39'h0000, 8'd3));
    boot(16'd0, 16'd0, 16'd1);
    repeat (5) @(negedge clock);
    drained("send_drain");

    // Cadence: 2 body + 1 epi + 3 sleep = 6 clocks per virtual cycle.
    do_reset();
    prog = '{ins(4'd0, 11'd0, 11'd0, 11'd0, 16'd0), ins(4'd0, 11'd0, 11'd0, 11'd0, 16'd0)};
    exp_q.push_back(ev(4'h2, 39'h0000, 8'd19));
    boot(16'd1, 16'd3, 16'd3);
    for (int k = 1; k <= 18; k++) begin
      check($sformatf("cadence_k%0d", k), {active, dyn_cycle, debug_time},
            {1'b1, ((k - 1) % 6) == 0, ((k - 1) % 6) < 2});
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    drained("cadence_drain");

    // EXPECT on the last body slot beats countdown expiry in the same cycle.
    do_reset();
    prog = '{ins(4'd1, 11'd1, 11'd0, 11'd0, 16'd1),
             ins(4'd1, 11'd2, 11'd0, 11'd0, 16'd2),
             ins(4'd6, 11'd0, 11'd1, 11'd2, 16'h8007)};
    exp_q.push_back(ev(4'h2, 39'h8007, 8'd4));
    boot(16'd0, 16'd0, 16'd1);
    repeat (5) @(negedge clock);
    drained("prec_drain");

    // COUNT = 0: exception without ever going active.
    do_reset();
    pass_program();
    exp_q.push_back(ev(4'h2, 39'h0000, 8'd1));
    boot(16'd1, 16'd1, 16'd0);
    check("count0_active", {active, dyn_cycle}, 2'b00);
    repeat (3) @(negedge clock);
    drained("count0_drain");

    // Reset mid-boot after 5 body words, then a complete boot.
    do_reset();
    pass_program();
    pkt(ADDR_CTRL, 16'd3);
    send_instr(prog[0]);
    pkt(ADDR_BODY, prog[1][15:0]);
    reset = 1'b0;
    @(negedge clock);
    check_reset_state("midboot");
    reset = 1'b1;
    @(negedge clock);
    check("midboot_idle", 64'(dbg_state), 64'(S_IDLE));
    exp_q.push_back(ev(4'h2, 39'h0000, 8'd11));
    boot(16'd1, 16'd1, 16'd2);
    repeat (14) @(negedge clock);
    check("reboot_final", {active, exc_err, exc_id}, {1'b0, 1'b1, 16'h0000});
    drained("reboot_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
